// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - control sequencer for the multicycle multiply/divide unit
//
// Purpose:
//   Accepts a one-cycle request from the main control unit and fires the
//   multiply/divide start strobe. It then counts the unit's fixed latency and
//   pulses the HI/LO write enables together with done. busy tells the control
//   FSM when to stall. abort returns the sequencer to IDLE from any state.
//
// Configuration macro:
//   MD_DIV0_TRAP_EN - when defined, a divide by zero is screened in IDLE and
//                     takes the EXC path (div0_exc pulse, no start, no HI/LO
//                     write). When undefined, every divide runs normally and
//                     div0_exc is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   start request, sampled only in IDLE
//   op_div     in   0 = multiply, 1 = divide, sampled with req
//   abort      in   flush; cancels any operation and masks all strobes
//   operand_b  in   divisor (REG_B), sampled with req
//   md_start   out  start strobe to the multiply/divide unit
//   hi_we      out  HI register write enable
//   lo_we      out  LO register write enable
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
//   div0_exc   out  one-cycle divide-by-zero exception pulse

module md_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op_div,
    input  logic        abort,
    input  logic [31:0] operand_b,
    output logic        md_start,
    output logic        hi_we,
    output logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic        div0_exc
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef MD_DIV0_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXC,
        S_START,
        S_RUN,
        S_WB
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_WB
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic             wb_q;
    logic             exc_q;
    logic             busy_q;

    // The strobe registers are loaded on the edge that enters the state they
    // belong to, so every output is a clean flop decoded one edge early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            wb_q    <= 1'b0;
            exc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            wb_q    <= 1'b0;
            exc_q   <= 1'b0;
            if (abort) begin
                state  <= S_IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req) begin
                            busy_q <= 1'b1;
`ifdef MD_DIV0_TRAP_EN
                            if (op_div && (operand_b == 32'd0)) begin
                                state <= S_EXC;
                                exc_q <= 1'b1;
                            end else
`endif
                            begin
                                cnt     <= op_div ? DIV_LOAD : MULT_LOAD;
                                state   <= S_START;
                                start_q <= 1'b1;
                            end
                        end
                    end
`ifdef MD_DIV0_TRAP_EN
                    S_EXC: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
`endif
                    S_START: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        // Counter holds N on the first RUN cycle, so leaving
                        // when it reads 1 yields exactly N RUN cycles.
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= S_WB;
                            wb_q  <= 1'b1;
                        end
                    end
                    S_WB: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // abort kills strobes in the very cycle it is raised.
    assign md_start = start_q & ~abort;
    assign hi_we    = wb_q & ~abort;
    assign lo_we    = wb_q & ~abort;
    assign done     = wb_q & ~abort;
    assign busy     = busy_q;

`ifdef MD_DIV0_TRAP_EN
    assign div0_exc = exc_q & ~abort;
`else
    // Without the trap the divisor is never examined.
    logic unused_operand_b;
    assign unused_operand_b = ^operand_b;
    assign div0_exc         = exc_q & 1'b0;
`endif

endmodule
